band_level_meter: RTL and testbench

Downstream consumer of fir_filter. It takes each 48-bit signed band-filtered sample, qualified by the filter's out_ready strobe, and converts it to a 16-bit magnitude. A peak envelope with instant attack and exponential decay is derived from that magnitude, and its top 8 bits become the brightness level. The level drives one lamp/LED channel of the light-music display through a glitch-free PWM output.

---
 rtl/light_music_pkg.sv | 11 +
 rtl/level_pwm.sv | 29 ++
 rtl/band_level_meter.sv | 82 ++++++++
 tb/tb_band_level_meter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/light_music_pkg.sv
// light_music_pkg: shared widths and types for the light-music signal chain
//   FIR_OUT_W : width of the band-filtered sample coming out of fir_filter
//   MAG_W     : width of the saturated sample magnitude and of the peak envelope
//   LEVEL_W   : width of a brightness level / PWM duty value
package light_music_pkg;
   localparam int FIR_OUT_W = 48;
   localparam int MAG_W     = 16;
   localparam int LEVEL_W   = 8;
   typedef logic [MAG_W-1:0]   mag_t;
   typedef logic [LEVEL_W-1:0] level_t;
endpackage

// File: rtl/level_pwm.sv
// level_pwm: glitch-free PWM driver for one lamp/LED channel
//   clk     in  system clock
//   nreset  in  asynchronous active-low reset
//   duty    in  requested duty, sampled only at the end of each period
//   pwm_out out registered PWM, high for duty out of 2^W cycles
module level_pwm
   import light_music_pkg::*;
#(
   parameter int W = LEVEL_W
) (
   input  logic         clk,
   input  logic         nreset,
   input  logic [W-1:0] duty,
   output logic         pwm_out
);
   logic [W-1:0] pwm_cnt;
   logic [W-1:0] pwm_duty;
   // duty is latched only in the wrap cycle so a period is never cut short or stretched
   always_ff @(posedge clk or negedge nreset)
      if (!nreset) begin
         pwm_cnt  <= '0;
         pwm_duty <= '0;
         pwm_out  <= 1'b0;
      end else begin
         pwm_cnt  <= pwm_cnt + W'(1);
         if (&pwm_cnt) pwm_duty <= duty;
         pwm_out  <= pwm_cnt < pwm_duty;
      end
endmodule

// File: rtl/band_level_meter.sv
// band_level_meter: converts band-filtered samples into a peak-envelope brightness level and PWM
//   clk         in  system clock (shared with fir_filter)
//   nreset      in  asynchronous active-low reset
//   in_val      in  signed filtered sample
//   in_ready    in  one-cycle strobe qualifying in_val
//   level       out envelope brightness, peak[15:8]
//   level_valid out one-cycle pulse when level updates (two cycles after in_ready)
//   overload    out high while within OVL_HOLD samples of a saturated magnitude
//   pwm_out     out PWM of level, period 2^PWM_W cycles
module band_level_meter
   import light_music_pkg::*;
#(
   parameter int IN_W     = FIR_OUT_W,
   parameter int SHIFT    = 24,
   parameter int DECAY_SH = 6,
   parameter int OVL_HOLD = 4096,
   parameter int PWM_W    = LEVEL_W
) (
   input  logic             clk,
   input  logic             nreset,
   input  logic [IN_W-1:0]  in_val,
   input  logic             in_ready,
   output logic [PWM_W-1:0] level,
   output logic             level_valid,
   output logic             overload,
   output logic             pwm_out
);
   localparam int SH_W  = IN_W - SHIFT;
   localparam int OVL_W = $clog2(OVL_HOLD + 1);
   logic [IN_W-1:0]  abs_v;
   logic [SH_W-1:0]  sh;
   logic [SHIFT-1:0] unused_lo;
   logic             sh_sat;
   logic             s1_valid;
   logic             sat;
   mag_t             mag;
   mag_t             peak;
   mag_t             d;
   mag_t             next_peak;
   logic [OVL_W-1:0] ovl_cnt;
   // taken as unsigned, the two's-complement negate of the most negative value is exactly 2^(IN_W-1)
   assign abs_v = in_val[IN_W-1] ? -in_val : in_val;
   assign {sh, unused_lo} = abs_v;
   assign sh_sat = |(sh >> MAG_W);
   assign d = peak >> DECAY_SH;
   // once the proportional decay rounds to zero, step down by one so the envelope always reaches 0
   always_comb
      next_peak = (mag >= peak) ? mag :
                  (d != '0)     ? peak - d :
                  (peak != '0)  ? peak - MAG_W'(1) : peak;
   always_ff @(posedge clk or negedge nreset)
      if (!nreset) begin
         s1_valid    <= 1'b0;
         mag         <= '0;
         sat         <= 1'b0;
         peak        <= '0;
         level       <= '0;
         level_valid <= 1'b0;
         ovl_cnt     <= '0;
      end else begin
         s1_valid    <= in_ready;
         level_valid <= s1_valid;
         if (in_ready) begin
            mag <= sh_sat ? '1 : sh[MAG_W-1:0];
            sat <= sh_sat;
         end
         // overload hold counts samples, so it only moves when a sample reaches stage 2
         if (s1_valid) begin
            peak    <= next_peak;
            level   <= next_peak[MAG_W-1 -: PWM_W];
            ovl_cnt <= sat              ? OVL_W'(OVL_HOLD) :
                       (ovl_cnt != '0)  ? ovl_cnt - OVL_W'(1) : ovl_cnt;
         end
      end
   assign overload = ovl_cnt != '0;
   level_pwm #(.W(PWM_W)) u_pwm (
      .clk    (clk),
      .nreset (nreset),
      .duty   (level),
      .pwm_out(pwm_out)
   );
endmodule

// File: tb/tb_band_level_meter.sv
// tb_band_level_meter: table-driven and scoreboard bench for band_level_meter
module tb_band_level_meter;
   logic        clk = 1'b0;
   logic        nreset;
   logic        in_ready;
   logic [47:0] in_val;
   logic [7:0]  level;
   logic        level_valid;
   logic        overload;
   logic        pwm_out;

   typedef struct {
      int         due;
      logic [7:0] lvl;
      logic       ovl;
   } exp_t;

   typedef struct {
      logic [47:0] v;
      logic [7:0]  lvl;
      logic        ovl;
   } vec_t;

   exp_t q[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   m_peak = 0;
   int   m_cnt = 0;

   band_level_meter dut (
      .clk        (clk),
      .nreset     (nreset),
      .in_val     (in_val),
      .in_ready   (in_ready),
      .level      (level),
      .level_valid(level_valid),
      .overload   (overload),
      .pwm_out    (pwm_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   function automatic void chk(input string name, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // reference envelope: instant attack, peak/64 decay with a minimum step of 1, sample-counted overload hold
   function automatic void model_step(input logic [47:0] v, output logic [7:0] el, output logic eo);
      longint a;
      int     mg;
      bit     st;
      a = longint'($signed(v));
      if (a < 0) a = -a;
      a = a >> 24;
      st = a > 65535;
      mg = st ? 65535 : int'(a);
      if (mg >= m_peak) m_peak = mg;
      else m_peak -= (m_peak / 64 > 0) ? m_peak / 64 : 1;
      m_cnt = st ? 4096 : (m_cnt > 0 ? m_cnt - 1 : 0);
      el = 8'(m_peak >> 8);
      eo = m_cnt != 0;
   endfunction

   task automatic push_drive(input logic [47:0] v, input logic [7:0] el, input logic eo);
      exp_t e;
      @(negedge clk);
      in_val   = v;
      in_ready = 1'b1;
      e.due = cyc + 2;
      e.lvl = el;
      e.ovl = eo;
      q.push_back(e);
   endtask

   task automatic send(input logic [47:0] v);
      logic [7:0] el;
      logic       eo;
      model_step(v, el, eo);
      push_drive(v, el, eo);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         in_ready = 1'b0;
      end
   endtask

   task automatic count_high(input int n, output int hi);
      hi = 0;
      repeat (n) begin
         @(posedge clk);
         #1;
         hi += int'(pwm_out);
      end
   endtask

   task automatic wait_rise(output bit ok);
      logic prev;
      ok = 1'b0;
      prev = pwm_out;
      for (int i = 0; i < 600 && !ok; i++) begin
         @(posedge clk);
         #1;
         if (pwm_out && !prev) ok = 1'b1;
         prev = pwm_out;
      end
   endtask

   // scoreboard: every level_valid pops one expectation, and its cycle must match the due cycle
   always @(posedge clk) begin : monitor
      exp_t e;
      #1;
      if (nreset) begin
         if (level_valid) begin
            if (q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_level_valid: got 1 expected 0 (cycle %0d)", cyc);
            end else begin
               e = q.pop_front();
               chk("lv_latency", cyc, e.due);
               chk("level", level, e.lvl);
               chk("overload", overload, e.ovl);
            end
         end else if (q.size() > 0 && q[0].due <= cyc) begin
            n_chk++;
            n_fail++;
            $display("FAIL missing_level_valid: got 0 expected 1 (due cycle %0d, now %0d)", q[0].due, cyc);
            void'(q.pop_front());
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      vec_t       tbl[9];
      logic [7:0] el;
      logic       eo;
      int         hi;
      int         seen;
      bit         ok;
      exp_t       e;
      tbl[0] = '{48'h0001_0000_0000, 8'h01, 1'b0};
      tbl[1] = '{48'hFF80_0000_0000, 8'h80, 1'b0};
      tbl[2] = '{48'h0000_0000_0000, 8'h7E, 1'b0};
      tbl[3] = '{48'h0000_0000_0000, 8'h7C, 1'b0};
      tbl[4] = '{48'h0012_3400_0000, 8'h7A, 1'b0};
      tbl[5] = '{48'h00FF_FF00_0000, 8'hFF, 1'b0};
      tbl[6] = '{48'h00FF_FFFF_FFFF, 8'hFF, 1'b0};
      tbl[7] = '{48'h0100_0000_0000, 8'hFF, 1'b1};
      tbl[8] = '{48'h0000_0000_0000, 8'hFC, 1'b1};
      nreset   = 1'b1;
      in_ready = 1'b0;
      in_val   = '0;
      #2 nreset = 1'b0;
      // reset held while strobes toggle: nothing may move
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         in_ready = ~in_ready;
         in_val   = 48'h7FFF_FFFF_FFFF;
      end
      @(posedge clk);
      #1;
      chk("rst_level", level, 0);
      chk("rst_level_valid", level_valid, 0);
      chk("rst_overload", overload, 0);
      chk("rst_pwm_out", pwm_out, 0);
      @(negedge clk);
      in_ready = 1'b0;
      nreset   = 1'b1;
      hi = 0;
      seen = 0;
      repeat (300) begin
         @(posedge clk);
         #1;
         hi += int'(pwm_out);
         seen += int'(level != 0);
      end
      chk("post_rst_pwm_high", hi, 0);
      chk("post_rst_level_nonzero", seen, 0);
      // back-to-back table vectors: attack, decay, sub-saturation edges, saturation
      for (int i = 0; i < 9; i++) begin
         model_step(tbl[i].v, el, eo);
         push_drive(tbl[i].v, tbl[i].lvl, tbl[i].ovl);
      end
      idle(4);
      // saturation from the positive extreme, then 4096 zero samples with idle gaps
      send(48'h7FFF_FFFF_FFFF);
      for (int i = 0; i < 4095; i++) begin
         send(48'h0);
         if (i % 5 == 4) idle(1);
      end
      idle(3);
      chk("overload_after_4095", overload, 1);
      send(48'h0);
      idle(3);
      chk("overload_after_4096", overload, 0);
      chk("level_decayed_zero", level, 0);
      // negative extreme must saturate without sign wrap
      model_step(48'h8000_0000_0000, el, eo);
      push_drive(48'h8000_0000_0000, 8'hFF, 1'b1);
      idle(3);
      chk("neg_extreme_overload", overload, 1);
      // reset while a sample sits in stage 1: no level_valid may follow
      @(negedge clk);
      in_val   = 48'h0010_0000_0000;
      in_ready = 1'b1;
      @(negedge clk);
      in_ready = 1'b0;
      nreset   = 1'b0;
      q.delete();
      m_peak = 0;
      m_cnt  = 0;
      @(negedge clk);
      chk("midrst_overload", overload, 0);
      chk("midrst_level", level, 0);
      @(negedge clk);
      nreset = 1'b1;
      seen = 0;
      repeat (6) begin
         @(posedge clk);
         #1;
         seen += int'(level_valid);
      end
      chk("midrst_no_level_valid", seen, 0);
      // level 0 with live samples: PWM never high
      send(48'h0000_FF00_0000);
      idle(1);
      count_high(600, hi);
      chk("pwm_level0_high", hi, 0);
      // level 0x40 then a mid-period change to 0xC0
      send(48'h0040_0000_0000);
      idle(1);
      wait_rise(ok);
      chk("pwm_rise_found", ok, 1);
      count_high(255, hi);
      chk("pwm_duty_40", hi + 1, 64);
      hi = 0;
      for (int i = 0; i < 256; i++) begin
         @(posedge clk);
         #1;
         hi += int'(pwm_out);
         if (i == 100) begin
            model_step(48'h00C0_0000_0000, el, eo);
            in_val   = 48'h00C0_0000_0000;
            in_ready = 1'b1;
            e.due = cyc + 2;
            e.lvl = el;
            e.ovl = eo;
            q.push_back(e);
         end
         if (i == 101) in_ready = 1'b0;
      end
      chk("pwm_duty_hold_midperiod", hi, 64);
      count_high(256, hi);
      chk("pwm_duty_c0", hi, 192);
      // full-scale level: high 255 of 256 cycles
      send(48'h00FF_FF00_0000);
      idle(300);
      count_high(256, hi);
      chk("pwm_duty_ff", hi, 255);
      idle(4);
      chk("queue_drained", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
